mul_seq_ctrl: RTL and testbench
===============================

MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 Parameter ITER_MAX, default 64, meaning multiplier operand width in bits (total bit positions to process); SHALL be even and >= 2.
REQ-002 Parameter CNT_W, default 7, meaning counter width; SHALL satisfy 2**CNT_W > ITER_MAX.
REQ-003 Port clk  input  1  single clock, all logic on rising edge.
REQ-004 Port reset  input  1  synchronous active-high reset.
REQ-005 Port op_start  input  1  request a new multiply.
REQ-006 Port op_clear  input  1  abort or acknowledge; return to IDLE.
REQ-007 Port op_radix4  input  1  mode select: 0 = 1 bit per step, 1 = 2 bits per step; sampled only when a start is accepted.
REQ-008 Port state  output  2  current state: IDLE=2'b00, LOAD=2'b01, EXEC=2'b10, DONE=2'b11.
REQ-009 Port counter  output  CNT_W  bit positions processed so far.
REQ-010 Port load_en  output  1  datapath operand-load strobe.
REQ-011 Port step_en  output  1  datapath add/shift strobe.
REQ-012 Port shift2  output  1  latched mode; 1 = datapath shifts by 2 this operation.
REQ-013 Port busy  output  1  high in LOAD or EXEC.
REQ-014 Port op_done  output  1  level, high in DONE.
REQ-015 Port done_pulse  output  1  single-cycle strobe on DONE entry.

Function
REQ-016 State and counter SHALL be registered; all strobes SHALL decode combinationally from the registered state only (no input-to-output paths).
REQ-017 op_clear SHALL have top priority after reset: next state IDLE, counter 0, shift2 0, from any state.
REQ-018 IDLE: op_start=1 and op_clear=0 -> LOAD; shift2 <= op_radix4; counter <= 0; otherwise stay IDLE.
REQ-019 LOAD SHALL last exactly one cycle with load_en=1, then go to EXEC with counter 0.
REQ-020 EXEC: step_en=1 each cycle; counter SHALL increment by 1 (shift2=0) or 2 (shift2=1) per edge.
REQ-021 EXEC: when counter + step == ITER_MAX at an edge, the next state SHALL be DONE and counter SHALL equal ITER_MAX; counter SHALL never exceed ITER_MAX or wrap.
REQ-022 EXEC SHALL occupy exactly ITER_MAX cycles (shift2=0) or ITER_MAX/2 cycles (shift2=1).
REQ-023 op_start SHALL be ignored in LOAD and EXEC; op_radix4 changes there SHALL not affect shift2.
REQ-024 DONE: counter and shift2 hold; op_done=1; op_start=1 with op_clear=0 -> LOAD with new mode latched and counter 0 (back-to-back restart).
REQ-025 done_pulse SHALL be high only in the first cycle of each DONE residency.
REQ-026 An unencoded or corrupted state value SHALL recover to IDLE on the next edge.

Reset
REQ-027 reset=1 at an edge SHALL force state IDLE, counter 0, shift2 0, regardless of all other inputs, including mid-EXEC.
REQ-028 Reset outputs: load_en 0, step_en 0, busy 0, op_done 0, done_pulse 0.

Configuration
REQ-029 Macro MUL_SEQ_CTRL_HOLD_EN defined: input op_hold (1 bit) SHALL exist; op_hold=1 in EXEC freezes counter and state, forces step_en 0; op_clear and reset still override; op_hold has no effect in other states.
REQ-030 Macro MUL_SEQ_CTRL_HOLD_EN undefined: no op_hold port; EXEC never stalls.

Verification (ITER_MAX=64, CNT_W=7)
REQ-031 op_start=1, op_radix4=0 at edge E -> LOAD after E, EXEC after E+1, DONE after E+65, counter=64, done_pulse exactly one cycle, 64 step_en cycles.
REQ-032 Same with op_radix4=1 -> DONE after E+33, counter=64, 32 step_en cycles, shift2=1 throughout.
REQ-033 op_clear=1 at EXEC counter=20 -> IDLE, counter 0, busy 0 next cycle; op_start and op_clear together in IDLE -> stays IDLE.
REQ-034 In DONE, op_start=1, op_radix4=1 -> LOAD, counter 0, shift2=1; second done_pulse follows after 33 further edges.
REQ-035 reset=1 at EXEC counter=40 with op_start=1 -> IDLE, all outputs at reset values next cycle.
REQ-036 With MUL_SEQ_CTRL_HOLD_EN: op_hold=1 for 5 cycles at counter=10 (radix-2) -> counter stays 10, step_en 0; DONE arrives 5 cycles later than REQ-031.

Source files
------------

// File: rtl/mul_seq_ctrl_if.sv
// mul_seq_ctrl_if
// Purpose: bundles the command and status signals of the sequential
// multiplier controller so one handle can pass between the datapath
// driver and the controller.
// Signals:
//   op_start   - request a new multiply
//   op_clear   - abort or acknowledge, returns controller to IDLE
//   op_radix4  - mode select (0 = 1 bit per step, 1 = 2 bits per step)
//   state      - current controller state (IDLE/LOAD/EXEC/DONE)
//   counter    - bit positions processed so far
//   load_en    - datapath operand-load strobe
//   step_en    - datapath add/shift strobe
//   shift2     - latched mode for the running operation
//   busy       - high in LOAD or EXEC
//   op_done    - level, high in DONE
//   done_pulse - single-cycle strobe on DONE entry
// Modports: master drives the commands, slave is the controller.
interface mul_seq_ctrl_if #(
  parameter int CNT_W = 7
);
  logic             op_start;
  logic             op_clear;
  logic             op_radix4;
  logic [1:0]       state;
  logic [CNT_W-1:0] counter;
  logic             load_en;
  logic             step_en;
  logic             shift2;
  logic             busy;
  logic             op_done;
  logic             done_pulse;

  modport master (
    output op_start, op_clear, op_radix4,
    input  state, counter, load_en, step_en, shift2, busy, op_done, done_pulse
  );

  modport slave (
    input  op_start, op_clear, op_radix4,
    output state, counter, load_en, step_en, shift2, busy, op_done, done_pulse
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl
// Purpose: control FSM for a sequential shift/add multiplier. Walks the
// multiplier operand one bit (radix-2) or two bits (radix-4) per EXEC
// cycle and reports completion.
// Ports:
//   clk     - single clock, rising edge
//   reset   - synchronous active-high reset
//   op_hold - EXEC stall request (only when MUL_SEQ_CTRL_HOLD_EN is defined)
//   bus     - mul_seq_ctrl_if.slave command/status bundle
// Parameters:
//   ITER_MAX - multiplier width in bits, even and >= 2
//   CNT_W    - counter width, 2**CNT_W > ITER_MAX
// Configuration:
//   MUL_SEQ_CTRL_HOLD_EN - when defined, adds op_hold which freezes EXEC.
module mul_seq_ctrl #(
  parameter int ITER_MAX = 64,
  parameter int CNT_W    = 7
) (
  input  logic clk,
  input  logic reset,
`ifdef MUL_SEQ_CTRL_HOLD_EN
  input  logic op_hold,
`endif
  mul_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_EXEC = 2'b10,
    S_DONE = 2'b11
  } state_t;

  // One extra bit so the end-of-operation compare cannot wrap.
  localparam logic [CNT_W:0] ITER_LIM = (CNT_W+1)'(ITER_MAX);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic             shift2_q, shift2_d;
  logic             first_q, first_d;
  logic [CNT_W:0]   count_next;
  logic             hold_exec;

  // Stall qualifier; tied off when the hold feature is not built in.
`ifdef MUL_SEQ_CTRL_HOLD_EN
  assign hold_exec = op_hold && (state_q == S_EXEC);
`else
  assign hold_exec = 1'b0;
`endif

  // Counter advance for this EXEC cycle, computed wide so the completion
  // test sees the true sum rather than a wrapped value.
  assign count_next = {1'b0, counter_q} + (shift2_q ? (CNT_W+1)'(2) : (CNT_W+1)'(1));

  // Next-state logic. op_clear overrides every state; any encoding that
  // is not a legal state falls back to IDLE. first_d marks the first
  // cycle of a DONE residency so done_pulse comes out of a flop.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    shift2_d  = shift2_q;
    if (bus.op_clear) begin
      state_d   = S_IDLE;
      counter_d = '0;
      shift2_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.op_start) begin
            state_d   = S_LOAD;
            counter_d = '0;
            shift2_d  = bus.op_radix4;
          end
        end
        S_LOAD: begin
          state_d   = S_EXEC;
          counter_d = '0;
        end
        S_EXEC: begin
          if (!hold_exec) begin
            if (count_next >= ITER_LIM) begin
              state_d   = S_DONE;
              counter_d = ITER_LIM[CNT_W-1:0];
            end else begin
              counter_d = count_next[CNT_W-1:0];
            end
          end
        end
        S_DONE: begin
          if (bus.op_start) begin
            state_d   = S_LOAD;
            counter_d = '0;
            shift2_d  = bus.op_radix4;
          end
        end
        default: begin
          state_d   = S_IDLE;
          counter_d = '0;
          shift2_d  = 1'b0;
        end
      endcase
    end
    first_d = (state_d == S_DONE) && (state_q != S_DONE);
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      counter_q <= '0;
      shift2_q  <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      shift2_q  <= shift2_d;
      first_q   <= first_d;
    end
  end

  // Strobes decode only from registered state (plus the optional stall).
  assign bus.state      = state_q;
  assign bus.counter    = counter_q;
  assign bus.shift2     = shift2_q;
  assign bus.load_en    = (state_q == S_LOAD);
  assign bus.step_en    = (state_q == S_EXEC) && !hold_exec;
  assign bus.busy       = (state_q == S_LOAD) || (state_q == S_EXEC);
  assign bus.op_done    = (state_q == S_DONE);
  assign bus.done_pulse = (state_q == S_DONE) && first_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl
// Purpose: self-checking bench for mul_seq_ctrl. A timeline model tracks
// how many edges have passed since a start was accepted and derives every
// output from that, compared each cycle; directed scenarios add literal
// expectations for latency, step counts and clear/reset behaviour.
module tb_mul_seq_ctrl;

  localparam int ITER_MAX = 64;
  localparam int CNT_W    = 7;
`ifdef MUL_SEQ_CTRL_HOLD_EN
  localparam bit HOLD_FEATURE = 1'b1;
`else
  localparam bit HOLD_FEATURE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic op_hold = 1'b0;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  t0 = 0;
  int  step_cnt = 0;
  int  pulse_cnt = 0;
  bit  check_en = 1'b0;

  int  m_active = 0;
  int  m_t = 0;
  int  m_mode = 0;

  mul_seq_ctrl_if #(.CNT_W(CNT_W)) bus();

  mul_seq_ctrl #(.ITER_MAX(ITER_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .reset(reset),
`ifdef MUL_SEQ_CTRL_HOLD_EN
    .op_hold(op_hold),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  function automatic int exp_len();
    return (m_mode != 0) ? ITER_MAX / 2 : ITER_MAX;
  endfunction

  function automatic int exp_state();
    if (m_active == 0) return 0;
    if (m_t == 1) return 1;
    if (m_t <= exp_len() + 1) return 2;
    return 3;
  endfunction

  function automatic int exp_counter();
    if (exp_state() == 2) return (m_t - 2) * ((m_mode != 0) ? 2 : 1);
    if (exp_state() == 3) return ITER_MAX;
    return 0;
  endfunction

  function automatic bit hold_now();
    return HOLD_FEATURE && op_hold;
  endfunction

  // Timeline model: m_t counts edges since a start was accepted. LOAD is
  // t=1, EXEC spans t=2..L+1, DONE begins at t=L+2.
  always @(posedge clk) begin
    if (reset || bus.op_clear) begin
      m_active = 0;
      m_t      = 0;
      m_mode   = 0;
    end else if (m_active == 0) begin
      if (bus.op_start) begin
        m_active = 1;
        m_t      = 1;
        m_mode   = int'(bus.op_radix4);
      end
    end else if (m_t >= exp_len() + 2) begin
      if (bus.op_start) begin
        m_t    = 1;
        m_mode = int'(bus.op_radix4);
      end else if (m_t < exp_len() + 3) begin
        m_t++;
      end
    end else if (!(m_t >= 2 && hold_now())) begin
      m_t++;
    end
  end

  // Per-cycle comparison against the model, plus strobe tallies.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("state", 32'(bus.state), 32'(exp_state()));
      checkOutput("counter", 32'(bus.counter), 32'(exp_counter()));
      checkOutput("shift2", 32'(bus.shift2), 32'(m_mode));
      checkOutput("load_en", 32'(bus.load_en), 32'(exp_state() == 1));
      checkOutput("step_en", 32'(bus.step_en), 32'((exp_state() == 2) && !hold_now()));
      checkOutput("busy", 32'(bus.busy), 32'(exp_state() == 1 || exp_state() == 2));
      checkOutput("op_done", 32'(bus.op_done), 32'(exp_state() == 3));
      checkOutput("done_pulse", 32'(bus.done_pulse), 32'(m_active != 0 && m_t == exp_len() + 2));
    end
    if (bus.step_en === 1'b1) step_cnt++;
    if (bus.done_pulse === 1'b1) pulse_cnt++;
  end

  task automatic applyStimulus(input logic start, input logic clear, input logic radix4);
    bus.op_start  = start;
    bus.op_clear  = clear;
    bus.op_radix4 = radix4;
  endtask

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Accepts a start on the next edge (E); returns one step after E.
  task automatic startOp(input logic radix4);
    step_cnt  = 0;
    pulse_cnt = 0;
    t0 = cyc;
    applyStimulus(1'b1, 1'b0, radix4);
    cycle(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic waitDone(output int edges);
    int n;
    n = 0;
    while (bus.state !== 2'b11 && n < 300) begin
      cycle(1);
      n++;
    end
    if (bus.state !== 2'b11) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_done timeout state=%0d", bus.state);
    end
    edges = cyc - t0;
  endtask

  task automatic waitCounter(input int target);
    int n;
    n = 0;
    while (int'(bus.counter) != target && n < 300) begin
      cycle(1);
      n++;
    end
    if (int'(bus.counter) != target) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_counter timeout counter=%0d wanted=%0d", bus.counter, target);
    end
  endtask

  // Directed scenarios.
  initial begin
    int edges;
    applyStimulus(1'b0, 1'b0, 1'b0);
    cycle(2);
    check_en = 1'b1;
    reset = 1'b0;
    checkOutput("reset_state", 32'(bus.state), 0);
    checkOutput("reset_counter", 32'(bus.counter), 0);
    checkOutput("reset_busy", 32'(bus.busy), 0);
    cycle(2);

    // Radix-2 run: DONE lands 65 edges after E, i.e. 66 edges counting E.
    startOp(1'b0);
    checkOutput("r2_load_state", 32'(bus.state), 1);
    checkOutput("r2_load_en", 32'(bus.load_en), 1);
    waitDone(edges);
    checkOutput("r2_done_edges", 32'(edges), 66);
    checkOutput("r2_done_counter", 32'(bus.counter), 64);
    cycle(3);
    checkOutput("r2_step_count", 32'(step_cnt), 64);
    checkOutput("r2_pulse_count", 32'(pulse_cnt), 1);
    checkOutput("r2_done_hold", 32'(bus.op_done), 1);

    // Back-to-back restart from DONE into radix-4.
    startOp(1'b1);
    checkOutput("rs_load_state", 32'(bus.state), 1);
    checkOutput("rs_load_counter", 32'(bus.counter), 0);
    checkOutput("rs_load_shift2", 32'(bus.shift2), 1);
    waitDone(edges);
    checkOutput("rs_done_edges", 32'(edges), 34);
    cycle(2);
    checkOutput("rs_step_count", 32'(step_cnt), 32);
    checkOutput("rs_pulse_count", 32'(pulse_cnt), 1);

    // Acknowledge with clear, then radix-4 from IDLE.
    applyStimulus(1'b0, 1'b1, 1'b0);
    cycle(1);
    checkOutput("ack_state", 32'(bus.state), 0);
    checkOutput("ack_shift2", 32'(bus.shift2), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    startOp(1'b1);
    waitDone(edges);
    checkOutput("r4_done_edges", 32'(edges), 34);
    checkOutput("r4_done_counter", 32'(bus.counter), 64);
    checkOutput("r4_shift2", 32'(bus.shift2), 1);
    cycle(1);
    checkOutput("r4_step_count", 32'(step_cnt), 32);
    applyStimulus(1'b0, 1'b1, 1'b0);
    cycle(1);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Abort mid-EXEC; start/mode toggles during EXEC must be ignored.
    startOp(1'b0);
    waitCounter(5);
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitCounter(20);
    checkOutput("clr_pre_shift2", 32'(bus.shift2), 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    cycle(1);
    checkOutput("clr_state", 32'(bus.state), 0);
    checkOutput("clr_counter", 32'(bus.counter), 0);
    checkOutput("clr_busy", 32'(bus.busy), 0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    cycle(1);
    checkOutput("start_clear_idle", 32'(bus.state), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    cycle(1);

    // Reset mid-EXEC with start held high.
    startOp(1'b0);
    waitCounter(40);
    reset = 1'b1;
    bus.op_start = 1'b1;
    cycle(1);
    checkOutput("rst_state", 32'(bus.state), 0);
    checkOutput("rst_counter", 32'(bus.counter), 0);
    checkOutput("rst_shift2", 32'(bus.shift2), 0);
    checkOutput("rst_strobes", 32'({bus.load_en, bus.step_en, bus.busy, bus.op_done, bus.done_pulse}), 0);
    reset = 1'b0;
    bus.op_start = 1'b0;
    cycle(2);

`ifdef MUL_SEQ_CTRL_HOLD_EN
    // Five-cycle stall at counter 10 pushes DONE out by five edges.
    startOp(1'b0);
    waitCounter(10);
    op_hold = 1'b1;
    cycle(5);
    checkOutput("hold_counter", 32'(bus.counter), 10);
    checkOutput("hold_step_en", 32'(bus.step_en), 0);
    op_hold = 1'b0;
    waitDone(edges);
    checkOutput("hold_done_edges", 32'(edges), 71);
    cycle(1);
    checkOutput("hold_step_count", 32'(step_cnt), 64);
    applyStimulus(1'b0, 1'b1, 1'b0);
    cycle(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
`endif

    cycle(2);
    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

endmodule
